// File: rtl/spi_bus_ctrl_pkg.sv
// spi_bus_ctrl_pkg
//   Shared definitions for the SPI-to-register-bus sequencer:
//   - state_t      : sequencer FSM encoding (IDLE, SPI_RD, SPI_WR, LOC)
//   - RW_BIT       : position of the R/W flag for the default 8-bit address
//   - rw_bit()     : R/W flag position for an arbitrary address width
//   - TO_RD_FILL   : bit pattern replicated into read data of a timed-out access
package spi_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPI_RD = 2'd1,
        SPI_WR = 2'd2,
        LOC    = 2'd3
    } state_t;

    localparam int SPI_AW_DEFAULT = 8;
    localparam int RW_BIT         = SPI_AW_DEFAULT - 1;

    // A timed-out read returns all ones.
    localparam logic TO_RD_FILL = 1'b1;

    // The R/W flag is always the MSB of the SPI address.
    function automatic int rw_bit(input int aw);
        return aw - 1;
    endfunction

endpackage

// File: rtl/spi_bus_ctrl_cs_edge_sync.sv
// cs_edge_sync
//   Brings an asynchronous chip-select pad signal into the clk domain through
//   a STAGES-deep flop chain, then compares it against one extra edge register
//   to form single-cycle edge pulses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw pad input
//   rise       : one-cycle pulse on a synchronized 0->1 transition
//   fall       : one-cycle pulse on a synchronized 1->0 transition
module cs_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;
    logic              edge_reg;

    // Each stage samples the one before it; stage 0 samples the pad.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = din;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            edge_reg <= sync_reg[STAGES-1];
        end
    end

    assign rise = sync_reg[STAGES-1] & ~edge_reg;
    assign fall = ~sync_reg[STAGES-1] & edge_reg;

endmodule

// File: rtl/spi_bus_ctrl.sv
// spi_bus_ctrl
//   Sequences register-bus accesses for a two-chip-select SPI slave and one
//   local FPGA master. The end of the SPI address phase (rising address CS)
//   latches the address; a read address triggers a prefetch so data is ready
//   in spi_din before the data phase, a write is committed after data_end.
//   SPI reads beat SPI writes beat local accesses; a running access is never
//   preempted.
// Optional feature: define SPI_BUS_CTRL_TIMEOUT_EN to add a bus-ack timeout
//   (TO_CYC cycles) that aborts the access, returns all ones for reads and
//   sets the sticky bus_err output.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   spi_cs_addr                   : raw address chip select (pad)
//   spi_addr, spi_dout            : address / data shifted in by the slave
//   data_begin, data_end          : data-CS fall / rise pulses
//   spi_din                       : read data for the slave transmit load
//   rd_late                       : data phase began before prefetch finished
//   loc_req/we/addr/wdata         : local master request (held until loc_done)
//   loc_done, loc_rdata           : local completion pulse and read data
//   bus_req/we/addr/wdata         : registered register-bus request
//   bus_ack, bus_rdata            : single-cycle ack with read data
//   bus_err                       : sticky timeout flag (timeout build only)
module spi_bus_ctrl
    import spi_bus_ctrl_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_cs_addr,
    input  logic [AW-1:0] spi_addr,
    input  logic [DW-1:0] spi_dout,
    input  logic          data_begin,
    input  logic          data_end,
    output logic [DW-1:0] spi_din,
    output logic          rd_late,
    input  logic          loc_req,
    input  logic          loc_we,
    input  logic [AW-2:0] loc_addr,
    input  logic [DW-1:0] loc_wdata,
    output logic          loc_done,
    output logic [DW-1:0] loc_rdata,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-2:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata
`ifdef SPI_BUS_CTRL_TIMEOUT_EN
    ,
    output logic          bus_err
`endif
);

    localparam int RW = rw_bit(AW);

    // ------------------------------------------------------------------
    // Address chip-select edge detection
    // ------------------------------------------------------------------
    logic cs_rise;
    logic cs_fall;
    logic cs_armed_reg;
    logic addr_done;

    cs_edge_sync #(
        .STAGES (2)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_cs_addr),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // The synchronizer resets to 0 while an idle CS pad sits high, which
    // would look like an address-phase end right after reset. Only a rise
    // that follows a seen fall counts as a completed address phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_armed_reg <= 1'b0;
        end else if (cs_fall) begin
            cs_armed_reg <= 1'b1;
        end else if (cs_rise) begin
            cs_armed_reg <= 1'b0;
        end
    end

    assign addr_done = cs_rise & cs_armed_reg;

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    state_t          state_reg;
    state_t          state_next;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            rd_pend_reg;
    logic            wr_pend_reg;
    logic            bus_req_reg;
    logic            bus_we_reg;
    logic [AW-2:0]   bus_addr_reg;
    logic [DW-1:0]   bus_wdata_reg;
    logic [DW-1:0]   spi_din_reg;
    logic            rd_late_reg;
    logic            loc_done_reg;
    logic [DW-1:0]   loc_rdata_reg;

    // acc_done marks the final cycle of an access (ack or timeout abort);
    // acc_rdata is the read data to capture in that cycle.
    logic            acc_done;
    logic [DW-1:0]   acc_rdata;
    logic            start;

`ifdef SPI_BUS_CTRL_TIMEOUT_EN
    localparam int CW = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;

    logic [CW-1:0] to_cnt_reg;
    logic          to_hit;
    logic          bus_err_reg;

    assign to_hit    = bus_req_reg && !bus_ack && (to_cnt_reg == CW'(TO_CYC - 1));
    assign acc_done  = (state_reg != IDLE) && (bus_ack || to_hit);
    assign acc_rdata = to_hit ? {DW{TO_RD_FILL}} : bus_rdata;

    // Counts request cycles of the current access; zero in its first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg  <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            if (!bus_req_reg || acc_done) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
            if (to_hit) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign bus_err = bus_err_reg;
`else
    assign acc_done  = (state_reg != IDLE) && bus_ack;
    assign acc_rdata = bus_rdata;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (rd_pend_reg) begin
                    state_next = SPI_RD;
                end else if (wr_pend_reg) begin
                    state_next = SPI_WR;
                end else if (loc_req && !loc_done_reg) begin
                    // While loc_done is showing, the master has not yet had
                    // a chance to drop loc_req; starting now would repeat
                    // the access it just completed.
                    state_next = LOC;
                end
            end
            default: begin
                if (acc_done) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    assign start = (state_reg == IDLE) && (state_next != IDLE);

    // ------------------------------------------------------------------
    // SPI address / data capture and pending flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_pend_reg <= 1'b0;
            wr_pend_reg <= 1'b0;
        end else begin
            if (addr_done) begin
                addr_q <= spi_addr;
            end

            // A new address decides the read flag; otherwise a finished
            // prefetch clears it.
            if (addr_done) begin
                rd_pend_reg <= ~spi_addr[RW];
            end else if (state_reg == SPI_RD && acc_done) begin
                rd_pend_reg <= 1'b0;
            end

            if (data_end && addr_q[RW]) begin
                wdata_q     <= spi_dout;
                wr_pend_reg <= 1'b1;
            end else if (state_reg == SPI_WR && acc_done) begin
                wr_pend_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register-bus request: loaded on leaving IDLE, held until completion
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
        end else if (start) begin
            bus_req_reg   <= 1'b1;
            bus_we_reg    <= (state_next == SPI_WR) || ((state_next == LOC) && loc_we);
            bus_addr_reg  <= (state_next == LOC) ? loc_addr : addr_q[AW-2:0];
            bus_wdata_reg <= (state_next == LOC) ? loc_wdata : wdata_q;
        end else if (acc_done) begin
            bus_req_reg   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Completion outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_din_reg   <= '0;
            rd_late_reg   <= 1'b0;
            loc_done_reg  <= 1'b0;
            loc_rdata_reg <= '0;
        end else begin
            // A late data phase still shifts out the old spi_din; the
            // prefetch keeps running and updates spi_din when it lands.
            rd_late_reg  <= data_begin && (rd_pend_reg || state_reg == SPI_RD);
            loc_done_reg <= (state_reg == LOC) && acc_done;

            if (state_reg == SPI_RD && acc_done) begin
                spi_din_reg <= acc_rdata;
            end
            if (state_reg == LOC && acc_done && !bus_we_reg) begin
                loc_rdata_reg <= acc_rdata;
            end
        end
    end

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign spi_din   = spi_din_reg;
    assign rd_late   = rd_late_reg;
    assign loc_done  = loc_done_reg;
    assign loc_rdata = loc_rdata_reg;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
`timescale 1ns/1ps
module tb_spi_bus_ctrl;

    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int IW     = AW - 1;
    localparam int TO_CYC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spi_cs_addr;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_dout;
    logic          data_begin;
    logic          data_end;
    logic [DW-1:0] spi_din;
    logic          rd_late;
    logic          loc_req;
    logic          loc_we;
    logic [IW-1:0] loc_addr;
    logic [DW-1:0] loc_wdata;
    logic          loc_done;
    logic [DW-1:0] loc_rdata;
    logic          bus_req;
    logic          bus_we;
    logic [IW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
`ifdef SPI_BUS_CTRL_TIMEOUT_EN
    logic          bus_err;
`endif

    always #5 clk = ~clk;

    spi_bus_ctrl #(
        .AW     (AW),
        .DW     (DW),
        .TO_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_cs_addr (spi_cs_addr),
        .spi_addr    (spi_addr),
        .spi_dout    (spi_dout),
        .data_begin  (data_begin),
        .data_end    (data_end),
        .spi_din     (spi_din),
        .rd_late     (rd_late),
        .loc_req     (loc_req),
        .loc_we      (loc_we),
        .loc_addr    (loc_addr),
        .loc_wdata   (loc_wdata),
        .loc_done    (loc_done),
        .loc_rdata   (loc_rdata),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
`ifdef SPI_BUS_CTRL_TIMEOUT_EN
        ,
        .bus_err     (bus_err)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic          we;
        logic [IW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            src;     // 0 = SPI, 1 = local master
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [128];   // what the register space should hold
    logic [DW-1:0] bus_mem [128];   // what the bus slave actually holds
    logic [DW-1:0] model_spi_din;
    int            checks      = 0;
    int            failures    = 0;
    int            cyc         = 0;
    int            loc_done_cnt = 0;
    int            ack_delay   = 0;
    bit            ack_hold    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Bus slave: acks after ack_delay request cycles
    // ------------------------------------------------------------------
    initial begin : responder
        int wait_cnt;
        wait_cnt  = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            if (!rst_n || !bus_req) begin
                wait_cnt = 0;
            end else if (!ack_hold) begin
                if (wait_cnt >= ack_delay) begin
                    bus_ack = 1'b1;
                    if (bus_we) bus_mem[bus_addr] = bus_wdata;
                    else        bus_rdata = bus_mem[bus_addr];
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares every acked access with the scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n && loc_done) loc_done_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && bus_req && bus_ack) begin
            $display("ACC cycle=%0d we=%0d addr=0x%02h wdata=0x%04h rdata=0x%04h",
                     cyc, bus_we, bus_addr, bus_wdata, bus_rdata);
            if (exp_q.size() == 0) begin
                chk("unexpected_access", {31'd0, bus_req}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("acc_we", {31'd0, bus_we}, {31'd0, mon_e.we});
                chk("acc_addr", {25'd0, bus_addr}, {25'd0, mon_e.addr});
                if (mon_e.we) chk("acc_wdata", {16'd0, bus_wdata}, {16'd0, mon_e.wdata});
                @(negedge clk);
                chk("req_low_after_ack", {31'd0, bus_req}, 32'd0);
                if (mon_e.src == 0 && !mon_e.we)
                    chk("spi_din", {16'd0, spi_din}, {16'd0, mon_e.rdata});
                if (mon_e.src == 1) begin
                    chk("loc_done", {31'd0, loc_done}, 32'd1);
                    if (!mon_e.we) chk("loc_rdata", {16'd0, loc_rdata}, {16'd0, mon_e.rdata});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_req(output int lat, input int t0);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_req) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) chk("req_timeout", 32'd0, 32'd1);
        lat = cyc - t0;
    endtask

    task automatic wait_done();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !bus_req) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) chk("done_timeout", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic spi_addr_phase(input logic [AW-1:0] a, output int t_rise);
        @(negedge clk);
        spi_addr    = a;
        spi_cs_addr = 1'b0;
        repeat (3) @(negedge clk);
        spi_cs_addr = 1'b1;
        t_rise      = cyc;
    endtask

    task automatic pulse_begin();
        @(negedge clk);
        data_begin = 1'b1;
        @(negedge clk);
        data_begin = 1'b0;
    endtask

    task automatic pulse_end();
        @(negedge clk);
        data_end = 1'b1;
        @(negedge clk);
        data_end = 1'b0;
    endtask

    task automatic spi_read(input logic [IW-1:0] a);
        exp_t e;
        int   t0;
        int   lat;
        e.we = 1'b0; e.addr = a; e.wdata = '0; e.rdata = ref_mem[a]; e.src = 0;
        exp_q.push_back(e);
        spi_addr_phase({1'b0, a}, t0);
        wait_req(lat, t0);
        chk("rd_latency", lat, 32'd4);
        wait_done();
        model_spi_din = e.rdata;
        chk("din_before_begin", {16'd0, spi_din}, {16'd0, model_spi_din});
        pulse_begin();
        chk("rd_late_on_time", {31'd0, rd_late}, 32'd0);
        pulse_end();
    endtask

    task automatic spi_write(input logic [IW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        int   t0;
        int   lat;
        spi_addr_phase({1'b1, a}, t0);
        repeat (4) @(negedge clk);
        pulse_begin();
        chk("rd_late_write", {31'd0, rd_late}, 32'd0);
        e.we = 1'b1; e.addr = a; e.wdata = d; e.rdata = '0; e.src = 0;
        exp_q.push_back(e);
        ref_mem[a] = d;
        @(negedge clk);
        spi_dout = d;
        data_end = 1'b1;
        t0       = cyc;
        @(negedge clk);
        data_end = 1'b0;
        wait_req(lat, t0);
        chk("wr_latency", lat, 32'd2);
        wait_done();
    endtask

    task automatic loc_access(input logic we, input logic [IW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        int   t0;
        int   lat;
        bit   seen;
        e.we = we; e.addr = a; e.wdata = d; e.rdata = we ? '0 : ref_mem[a]; e.src = 1;
        exp_q.push_back(e);
        if (we) ref_mem[a] = d;
        @(negedge clk);
        loc_we    = we;
        loc_addr  = a;
        loc_wdata = d;
        loc_req   = 1'b1;
        t0        = cyc;
        wait_req(lat, t0);
        chk("loc_latency", lat, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (loc_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("loc_done_timeout", 32'd0, 32'd1);
        loc_req = 1'b0;
        wait_done();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : stim
        exp_t e1;
        exp_t e2;
        int   t0;
        int   lat;
        int   c0;
        bit   seen;

        rst_n       = 1'b0;
        spi_cs_addr = 1'b1;
        spi_addr    = '0;
        spi_dout    = '0;
        data_begin  = 1'b0;
        data_end    = 1'b0;
        loc_req     = 1'b0;
        loc_we      = 1'b0;
        loc_addr    = '0;
        loc_wdata   = '0;
        model_spi_din = '0;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = DW'($urandom);
            bus_mem[i] = ref_mem[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", {25'd0, bus_addr}, 32'd0);
        chk("rst_bus_wdata", {16'd0, bus_wdata}, 32'd0);
        chk("rst_spi_din", {16'd0, spi_din}, 32'd0);
        chk("rst_rd_late", {31'd0, rd_late}, 32'd0);
        chk("rst_loc_done", {31'd0, loc_done}, 32'd0);
        chk("rst_loc_rdata", {16'd0, loc_rdata}, 32'd0);
`ifdef SPI_BUS_CTRL_TIMEOUT_EN
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed read of 0x05 and write of 0x83/0xBEEF
        ref_mem[5] = 16'h1234;
        bus_mem[5] = 16'h1234;
        ack_delay  = 0;
        spi_read(7'h05);
        spi_write(7'h03, 16'hBEEF);
        chk("write_landed", {16'd0, bus_mem[3]}, 32'h0000BEEF);

        // Randomized mix of SPI and local accesses
        for (int n = 0; n < 40; n++) begin
            logic [IW-1:0] ra;
            logic [DW-1:0] rd;
            int            op;
            ra        = IW'($urandom_range(0, 127));
            rd        = DW'($urandom);
            op        = $urandom_range(0, 3);
            ack_delay = $urandom_range(0, 3);
            case (op)
                0:       spi_read(ra);
                1:       spi_write(ra, rd);
                2:       loc_access(1'b0, ra, rd);
                default: loc_access(1'b1, ra, rd);
            endcase
        end

        // Contention: local request becomes visible together with the
        // pending prefetch; the prefetch goes first, then the local write.
        ack_delay = 0;
        e1.we = 1'b0; e1.addr = 7'h21; e1.wdata = '0; e1.rdata = ref_mem[7'h21]; e1.src = 0;
        e2.we = 1'b1; e2.addr = 7'h22; e2.wdata = 16'hC0DE; e2.rdata = '0; e2.src = 1;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        ref_mem[7'h22] = 16'hC0DE;
        c0 = loc_done_cnt;
        spi_addr_phase({1'b0, 7'h21}, t0);
        repeat (3) @(negedge clk);
        loc_we    = 1'b1;
        loc_addr  = 7'h22;
        loc_wdata = 16'hC0DE;
        loc_req   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (loc_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("contention_timeout", 32'd0, 32'd1);
        loc_req = 1'b0;
        wait_done();
        chk("loc_done_once", loc_done_cnt - c0, 32'd1);
        model_spi_din = e1.rdata;
        chk("contention_spi_din", {16'd0, spi_din}, {16'd0, model_spi_din});
        pulse_begin();
        pulse_end();

        // Late read: data phase begins while the prefetch is still waiting
        ack_delay = 20;
        ref_mem[7'h30] = model_spi_din ^ 16'h5A5A;
        bus_mem[7'h30] = ref_mem[7'h30];
        e1.we = 1'b0; e1.addr = 7'h30; e1.wdata = '0; e1.rdata = ref_mem[7'h30]; e1.src = 0;
        exp_q.push_back(e1);
        spi_addr_phase({1'b0, 7'h30}, t0);
        repeat (5) @(negedge clk);
        data_begin = 1'b1;
        @(negedge clk);
        data_begin = 1'b0;
        chk("rd_late_pulse", {31'd0, rd_late}, 32'd1);
        chk("late_old_din", {16'd0, spi_din}, {16'd0, model_spi_din});
        @(negedge clk);
        chk("rd_late_single", {31'd0, rd_late}, 32'd0);
        wait_done();
        model_spi_din = e1.rdata;
        chk("late_new_din", {16'd0, spi_din}, {16'd0, model_spi_din});
        pulse_end();

        // Reset in the middle of a write: request drops at once, no reissue
        ack_hold  = 1'b1;
        ack_delay = 0;
        spi_addr_phase({1'b1, 7'h44}, t0);
        repeat (4) @(negedge clk);
        pulse_begin();
        @(negedge clk);
        spi_dout = 16'h7777;
        data_end = 1'b1;
        @(negedge clk);
        data_end = 1'b0;
        wait_req(lat, t0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_drops_req", {31'd0, bus_req}, 32'd0);
        exp_q.delete();
        model_spi_din = '0;
        repeat (3) @(negedge clk);
        ack_hold = 1'b0;
        rst_n    = 1'b1;
        c0 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_req) c0++;
        end
        chk("no_reissue", c0, 32'd0);
        chk("rst_clears_din", {16'd0, spi_din}, 32'd0);

`ifdef SPI_BUS_CTRL_TIMEOUT_EN
        // Timeout: no ack ever arrives
        chk("bus_err_clear", {31'd0, bus_err}, 32'd0);
        ack_hold = 1'b1;
        spi_addr_phase({1'b0, 7'h11}, t0);
        wait_req(lat, t0);
        c0 = 0;
        while (bus_req && c0 < 100) begin
            c0++;
            @(negedge clk);
        end
        chk("to_req_cycles", c0, TO_CYC);
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_spi_din", {16'd0, spi_din}, 32'h0000FFFF);
        ack_hold = 1'b0;
        repeat (5) @(negedge clk);
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_bus_ctrl.md
# spi_bus_ctrl

Transaction sequencer between the two-chip-select SPI slave (address phase on `spi_cs_addr`, data phase on `spi_cs_data`) and the FPGA's SRAM-like register bus. It decodes the received address, prefetches read data before the data phase so the slave can shift it out, and commits received write data when the data phase ends. It also shares the register bus with one local FPGA master, with SPI traffic taking priority.

## Interface
Parameters:
- `AW`, 8: SPI address width; `AW-1` is the R/W flag, `AW-2:0` is the register index.
- `DW`, 16: data width.
- `TO_CYC`, 255: bus-ack timeout in clk cycles. Used only with `SPI_BUS_CTRL_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `spi_cs_addr` in 1: raw address chip select from the pad; end of address phase is detected here.
- `spi_addr` in AW: address shifted in by the slave.
- `spi_dout` in DW: data shifted in by the slave.
- `data_begin` in 1: one-clk pulse at data-CS fall.
- `data_end` in 1: one-clk pulse at data-CS rise.
- `spi_din` out DW: read buffer presented to the slave's transmit load.
- `rd_late` out 1: one-clk pulse; `data_begin` arrived before the prefetch completed.
- `loc_req` in 1, `loc_we` in 1, `loc_addr` in AW-1, `loc_wdata` in DW: local master request, held until `loc_done`.
- `loc_done` out 1, `loc_rdata` out DW: local completion pulse and read data.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out AW-1, `bus_wdata` out DW: register bus request.
- `bus_ack` in 1, `bus_rdata` in DW: one-cycle acknowledge, with read data valid in the same cycle.
- `bus_err` out 1: sticky timeout flag. Exists only with the macro; cleared by reset.

## Operation
- `spi_cs_addr` passes through a 2-flop synchronizer plus an edge register. A rising edge means the address phase is complete: latch `spi_addr` into `addr_q`.
  - If `addr_q[AW-1]`=0 (read): set `rd_pend`.
  - If `addr_q[AW-1]`=1 (write): clear `rd_pend`.
- On `data_end` with the write flag set: latch `spi_dout` into `wdata_q` and set `wr_pend`. On `data_end` with a read address: no bus access.
- FSM states and transitions:
  - IDLE → SPI_RD if `rd_pend`.
  - IDLE → SPI_WR if `wr_pend` and not `rd_pend`.
  - IDLE → LOC if `loc_req` and no SPI pending.
  - SPI_RD, SPI_WR and LOC each return to IDLE on `bus_ack`.
- Priority is fixed: SPI_RD > SPI_WR > LOC.
- A LOC access is never preempted. SPI requests arriving during it stay pending.
- SPI_RD completion: on ack, `spi_din`←`bus_rdata` and `rd_pend` clears.
- SPI_WR completion: on ack, `wr_pend` clears.
- LOC completion:
  - On ack, `loc_done`=1 for one cycle.
  - `loc_rdata`←`bus_rdata` when `loc_we`=0; otherwise `loc_rdata` holds.
- `data_begin` while `rd_pend` or state SPI_RD:
  - Pulse `rd_late`.
  - `spi_din` keeps its old value; the prefetch still completes.
- A new address-phase end while `rd_pend` or `wr_pend` is set overwrites `addr_q`. A pending write then uses the new address. This is a protocol violation and the resulting behaviour is defined as stated.
- Reset values: all outputs 0, state IDLE, pend flags 0.
- Reset mid-access drops `bus_req` immediately.

## Timing
- `bus_req`, `bus_we`, `bus_addr` and `bus_wdata` are registered. They assert the cycle after leaving IDLE and hold stable until the ack cycle. `bus_req` is 0 in the cycle after ack.
- Minimum gap between accesses: 1 IDLE cycle.
- Latency, with `bus_ack` in the first request cycle:
  - Address-phase end on the pin → `bus_req`: 4 clk (2 synchronizer, 1 edge, 1 FSM).
  - `spi_din` valid: 1 clk after ack.
- `data_end` → write `bus_req`: 2 clk.
- `loc_req` → `bus_req` when idle: 1 clk.

## Configuration
- `SPI_BUS_CTRL_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter runs while `bus_req`=1.
  - At `TO_CYC` without ack: abort to IDLE and set `bus_err`.
  - The aborted access is reported as completed. A read returns all ones (to `spi_din` or `loc_rdata`); `loc_done` pulses for a LOC access.
- Undefined: no counter and no `bus_err` port; the FSM waits for ack indefinitely.

## Structure
- Package `spi_bus_ctrl_pkg` holds:
  - State encoding: IDLE, SPI_RD, SPI_WR, LOC.
  - `RW_BIT` = AW-1.
  - Timeout read pattern: all ones.
- Sub-module `cs_edge_sync`: 2-flop synchronizer plus rising/falling edge pulses. It is used for `spi_cs_addr`.

## Test plan
- Read: address phase with address 0x05, bus_rdata=0x1234 acked in 1 cycle → `bus_addr`=0x05, `bus_we`=0, `spi_din`=0x1234 before `data_begin`, `rd_late`=0.
- Write: address 0x83, data 0xBEEF, `data_end` → one access with `bus_addr`=0x03, `bus_we`=1, `bus_wdata`=0xBEEF.
- Contention: `loc_req` in the same cycle as the read prefetch becomes pending → SPI_RD is served first, LOC follows after 1 IDLE cycle, and `loc_done` pulses once.
- Late read: ack delayed 20 cycles with `data_begin` 5 cycles after address end → `rd_late` pulses, and `spi_din` updates after the ack.
- Timeout (macro on, `TO_CYC`=8): no ack → `bus_req` drops after 8 cycles, `bus_err`=1, `spi_din`=0xFFFF.
- Reset asserted mid-write → `bus_req`=0 immediately; after release the write is not reissued.
